lt24_bus_sequencer: RTL



---
 rtl/lt24_pkg.sv | 22 ++
 rtl/lt24_write_strobe.sv | 51 +++++
 rtl/lt24_bus_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lt24_pkg.sv
// Shared types and constants for the LT24 8080-style write bus sequencer.
package lt24_pkg;

    typedef enum logic [2:0] {
        RST_LOW,
        WAKE,
        IDLE,
        WR_LO,
        WR_HI,
        PIX_WAIT
    } lt24_seq_state_t;

    localparam logic [15:0] LT24_CMD_MEMORY_WRITE = 16'h002C;

    // Defaults assume a 50 MHz clock: 1 ms panel reset, 120 ms wake-up.
    localparam int LT24_RESET_CYCLES = 50000;
    localparam int LT24_WAKE_CYCLES  = 6000000;
    localparam int LT24_WR_LOW       = 2;
    localparam int LT24_WR_HIGH      = 2;
    localparam int LT24_FRAME_PIXELS = 76800;

endpackage

// File: rtl/lt24_write_strobe.sv
// wr_n phase generator: WR_LOW cycles low then WR_HIGH cycles high per start pulse.
// last_hi/done flag the final high cycle so a new write can follow back-to-back.
module lt24_write_strobe #(
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic wr_n,
    output logic last_hi,
    output logic done
);

    localparam int CMAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int CW   = $clog2(CMAX + 1);

    logic          active;
    logic          high_phase;
    logic [CW-1:0] cnt;

    // A start on the last high cycle restarts the low phase with no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            active     <= 1'b0;
            high_phase <= 1'b0;
            cnt        <= '0;
            wr_n       <= 1'b1;
        end else if (start) begin
            active     <= 1'b1;
            high_phase <= 1'b0;
            cnt        <= CW'(WR_LOW - 1);
            wr_n       <= 1'b0;
        end else if (active) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (!high_phase) begin
                high_phase <= 1'b1;
                cnt        <= CW'(WR_HIGH - 1);
                wr_n       <= 1'b1;
            end else begin
                active     <= 1'b0;
                high_phase <= 1'b0;
            end
        end
    end

    assign last_hi = active && high_phase && (cnt == '0);
    assign done    = last_hi;

endmodule

// File: rtl/lt24_bus_sequencer.sv
// LT24 panel power-up sequencer and command/pixel bus arbiter.
// Optional LT24_SEQ_IRQ_EN adds a sticky frame-done irq with irq_ack.
module lt24_bus_sequencer
    import lt24_pkg::*;
#(
    parameter int RESET_CYCLES = LT24_RESET_CYCLES,
    parameter int WAKE_CYCLES  = LT24_WAKE_CYCLES,
    parameter int WR_LOW       = LT24_WR_LOW,
    parameter int WR_HIGH      = LT24_WR_HIGH,
    parameter int FRAME_PIXELS = LT24_FRAME_PIXELS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_data,
    input  logic [15:0] cmd_word,
    input  logic        frame_start,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        init_done,
    output logic        busy,
    output logic        frame_done,
    output logic        cs_n,
    output logic        wr_n,
    output logic        rd_n,
    output logic        dc_n,
    output logic        lcd_on,
    output logic        lcd_reset_n,
    output logic [15:0] d
`ifdef LT24_SEQ_IRQ_EN
    ,
    output logic        irq,
    input  logic        irq_ack
`endif
);

    localparam int TMAX = (RESET_CYCLES > WAKE_CYCLES) ? RESET_CYCLES : WAKE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(FRAME_PIXELS + 1);

    lt24_seq_state_t state;
    logic [TW-1:0]   timer;
    logic [PW-1:0]   pix_cnt;
    logic            frame_pend;
    logic            in_frame;

    logic strobe_start, strobe_last_hi, strobe_done;
    logic in_write, start_frame, take_cmd, take_pix, frame_end;

    assign in_write    = (state == WR_LO) || (state == WR_HI);
    assign start_frame = (state == IDLE) && (frame_pend || frame_start);
    assign cmd_ready   = (state == IDLE) && init_done && !frame_pend && !frame_start;
    assign take_cmd    = cmd_valid && cmd_ready;
    // pix_cnt counts pixels already fetched, so FRAME_PIXELS means the last one is on the bus.
    assign pix_ready   = (in_write && in_frame && strobe_last_hi && (pix_cnt != PW'(FRAME_PIXELS)))
                         || (state == PIX_WAIT);
    assign take_pix    = pix_valid && pix_ready;
    assign frame_end   = in_write && in_frame && strobe_last_hi && (pix_cnt == PW'(FRAME_PIXELS));
    assign strobe_start = start_frame || take_cmd || take_pix;
    assign busy        = (state != IDLE) || frame_pend;
    assign rd_n        = 1'b1;

    lt24_write_strobe #(
        .WR_LOW (WR_LOW),
        .WR_HIGH(WR_HIGH)
    ) u_strobe (
        .clk    (clk),
        .reset  (reset),
        .start  (strobe_start),
        .wr_n   (wr_n),
        .last_hi(strobe_last_hi),
        .done   (strobe_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RST_LOW;
            timer       <= '0;
            pix_cnt     <= '0;
            frame_pend  <= 1'b0;
            in_frame    <= 1'b0;
            cs_n        <= 1'b1;
            dc_n        <= 1'b1;
            d           <= 16'h0000;
            lcd_reset_n <= 1'b0;
            lcd_on      <= 1'b0;
            init_done   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            lcd_on     <= 1'b1;
            frame_done <= 1'b0;
            if (frame_start && !in_frame && (state != IDLE)) begin
                frame_pend <= 1'b1;
            end
            case (state)
                RST_LOW: begin
                    if (timer == TW'(RESET_CYCLES - 1)) begin
                        state       <= WAKE;
                        timer       <= '0;
                        lcd_reset_n <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAKE: begin
                    if (timer == TW'(WAKE_CYCLES - 1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                IDLE: begin
                    if (start_frame) begin
                        state      <= WR_LO;
                        frame_pend <= 1'b0;
                        in_frame   <= 1'b1;
                        pix_cnt    <= '0;
                        cs_n       <= 1'b0;
                        dc_n       <= 1'b0;
                        d          <= LT24_CMD_MEMORY_WRITE;
                    end else if (take_cmd) begin
                        state <= WR_LO;
                        cs_n  <= 1'b0;
                        dc_n  <= cmd_is_data;
                        d     <= cmd_word;
                    end
                end
                WR_LO, WR_HI: begin
                    if (!in_frame && strobe_done) begin
                        state <= IDLE;
                        cs_n  <= 1'b1;
                    end else if (in_frame && strobe_last_hi) begin
                        if (frame_end) begin
                            state      <= IDLE;
                            cs_n       <= 1'b1;
                            in_frame   <= 1'b0;
                            frame_done <= 1'b1;
                        end else if (take_pix) begin
                            state   <= WR_LO;
                            d       <= pix_data;
                            dc_n    <= 1'b1;
                            pix_cnt <= pix_cnt + 1'b1;
                        end else begin
                            state <= PIX_WAIT;
                        end
                    end else if ((state == WR_LO) && wr_n) begin
                        state <= WR_HI;
                    end
                end
                PIX_WAIT: begin
                    if (take_pix) begin
                        state   <= WR_LO;
                        d       <= pix_data;
                        dc_n    <= 1'b1;
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                default: state <= RST_LOW;
            endcase
        end
    end

`ifdef LT24_SEQ_IRQ_EN
    // Set takes priority so an ack racing a new frame end never loses it.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (frame_end) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule
